// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg
//   Shared types and sizing helpers for the PWM line sequencer.
//   - seq_state_t : play-side FSM states.
//   - idx_w()     : bit width needed to index 0..n-1 (never below 1).
//   - LINE_CNT_W  : width of the completed-line counter.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } seq_state_t;

  localparam int unsigned LINE_CNT_W = 16;

  // Width of a counter/pointer that must hold values 0..n-1.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Larger of two sizes, used to share one timer between two waits.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_line_buffer.sv
// pwm_line_buffer
//   Ping-pong pair of line banks between the upstream byte stream and the
//   play-side FSM.  The fill side runs on its own: it writes accepted bytes
//   at fill_ptr, marks a bank full on its last byte and swaps to the other
//   bank.  Each bank also keeps a flag telling whether the whole line was 0.
//
// Ports
//   clkfordata    in   clock
//   rst           in   synchronous active-high reset
//   in_valid      in   upstream byte valid
//   in_ready      out  bank being filled has room (low during rst)
//   in_data       in   duty value, stage order 0..STAGE-1
//   play_sel      in   bank the FSM is playing
//   rd_ptr        in   byte index read from the play bank
//   release_bank  in   one-cycle pulse: mark the play bank empty
//   rd_data       out  play_bank[rd_ptr] (combinational read)
//   play_full     out  play bank holds a complete line
//   play_zero     out  play bank line is all zeros
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_valid may be held high; in_ready depends only on registered full
// flags and rst, never on in_valid.
module pwm_line_buffer
  import pwm_seq_pkg::*;
#(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  localparam int unsigned PTR_W = idx_w(STAGE)
) (
  input  logic              clkfordata,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              play_sel,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic              release_bank,
  output logic [DWIDTH-1:0] rd_data,
  output logic              play_full,
  output logic              play_zero
);

  logic [DWIDTH-1:0] mem [2][STAGE];
  logic              fill_sel;
  logic [PTR_W-1:0]  fill_ptr;
  logic [1:0]        full;
  logic [1:0]        zero;
  logic              zero_acc;   // all bytes so far in the current fill were 0
  logic              accept;
  logic              last_byte;
  logic              line_zero;  // zero flag including the byte being accepted

  assign in_ready  = !rst && !full[fill_sel];
  assign accept    = in_valid && in_ready;
  assign last_byte = (fill_ptr == PTR_W'(STAGE - 1));
  assign line_zero = (in_data == '0) && ((fill_ptr == '0) || zero_acc);

  // Storage carries no reset: a bank is only read after a full fill.
  always_ff @(posedge clkfordata) begin
    if (accept) begin
      mem[fill_sel][fill_ptr] <= in_data;
    end
  end

  always_ff @(posedge clkfordata) begin
    if (rst) begin
      fill_sel <= 1'b0;
      fill_ptr <= '0;
      zero_acc <= 1'b0;
      full     <= '0;
      zero     <= '0;
    end else begin
      if (accept) begin
        zero_acc <= line_zero;
        if (last_byte) begin
          fill_ptr <= '0;
          fill_sel <= ~fill_sel;
        end else begin
          fill_ptr <= fill_ptr + PTR_W'(1);
        end
      end
      // Release and completion never hit the same bank in one cycle: a bank
      // being filled is not full, and a full bank blocks acceptance, so
      // both events can be applied independently per bank.
      for (int b = 0; b < 2; b++) begin
        if (release_bank && (play_sel == 1'(b))) begin
          full[b] <= 1'b0;
        end else if (accept && last_byte && (fill_sel == 1'(b))) begin
          full[b] <= 1'b1;
          zero[b] <= line_zero;
        end
      end
    end
  end

  assign rd_data   = mem[play_sel][rd_ptr];
  assign play_full = full[play_sel];
  assign play_zero = zero[play_sel];

endmodule

// File: rtl/pwm_line_sequencer.sv
// pwm_line_sequencer
//   Buffers upstream duty bytes into lines of STAGE values and plays each
//   complete line into the PWM load port: one start pulse with byte 0, then
//   bytes 1..STAGE-1 on consecutive cycles.  It then waits for the PWM to
//   report busy and idle again, holds a blanking gap, releases the bank and
//   moves on to the other bank.
//
// Ports
//   clkfordata   in   sole clock
//   rst          in   synchronous active-high reset
//   enable       in   gates the start of a new line only
//   in_valid     in   upstream byte valid
//   in_ready     out  upstream byte accepted when in_valid && in_ready
//   in_data      in   duty value
//   pwm_start    out  start strobe to the PWM (registered)
//   pwm_data     out  duty value to the PWM (registered)
//   pwm_busy     in   OR of PWM outputs, already in this clock domain
//   line_done    out  one-cycle pulse per completed line
//   line_cnt     out  completed lines, wraps
//   err_timeout  out  sticky: a non-zero line never raised pwm_busy
//   dbg_state    out  current FSM state
module pwm_line_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int STAGE        = 8,
  parameter int DWIDTH       = 8,
  parameter int BUSY_TIMEOUT = 64,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  clkfordata,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DWIDTH-1:0]     in_data,
  output logic                  pwm_start,
  output logic [DWIDTH-1:0]     pwm_data,
  input  logic                  pwm_busy,
  output logic                  line_done,
  output logic [LINE_CNT_W-1:0] line_cnt,
  output logic                  err_timeout,
  output seq_state_t            dbg_state
);

  localparam int unsigned PTR_W = idx_w(STAGE);
  localparam int unsigned TMR_W = idx_w(max_u(BUSY_TIMEOUT, GAP_CYCLES));

  seq_state_t            state, state_n;
  logic [PTR_W-1:0]      play_ptr, play_ptr_n;   // byte currently on pwm_data
  logic [TMR_W-1:0]      timer, timer_n;         // busy timeout, then gap count
  logic                  play_sel, play_sel_n;
  logic                  start_n;
  logic [DWIDTH-1:0]     data_n;
  logic                  done_n;
  logic [LINE_CNT_W-1:0] cnt_n;
  logic                  err_n;
  logic                  release_bank;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DWIDTH-1:0]     rd_data;
  logic                  play_full;
  logic                  play_zero;

  pwm_line_buffer #(
    .STAGE  (STAGE),
    .DWIDTH (DWIDTH)
  ) u_buffer (
    .clkfordata   (clkfordata),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .play_sel     (play_sel),
    .rd_ptr       (rd_ptr),
    .release_bank (release_bank),
    .rd_data      (rd_data),
    .play_full    (play_full),
    .play_zero    (play_zero)
  );

  // Outputs are registered, so the byte loaded at each edge is the one that
  // will be on pwm_data next: byte 0 when leaving IDLE, play_ptr+1 in SEND.
  assign rd_ptr = (state == SEND) ? PTR_W'(play_ptr + PTR_W'(1)) : '0;

  always_ff @(posedge clkfordata) begin
    if (rst) begin
      state       <= IDLE;
      play_ptr    <= '0;
      timer       <= '0;
      play_sel    <= 1'b0;
      pwm_start   <= 1'b0;
      pwm_data    <= '0;
      line_done   <= 1'b0;
      line_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      play_ptr    <= play_ptr_n;
      timer       <= timer_n;
      play_sel    <= play_sel_n;
      pwm_start   <= start_n;
      pwm_data    <= data_n;
      line_done   <= done_n;
      line_cnt    <= cnt_n;
      err_timeout <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    play_ptr_n   = play_ptr;
    timer_n      = timer;
    play_sel_n   = play_sel;
    start_n      = 1'b0;
    data_n       = '0;
    done_n       = 1'b0;
    cnt_n        = line_cnt;
    err_n        = err_timeout;
    release_bank = 1'b0;

    case (state)
      IDLE: begin
        if (enable && play_full) begin
          state_n    = SEND;
          play_ptr_n = '0;
          start_n    = 1'b1;
          data_n     = rd_data;
        end
      end

      SEND: begin
        if (play_ptr == PTR_W'(STAGE - 1)) begin
          state_n = WAIT_BUSY;
          timer_n = '0;
        end else begin
          play_ptr_n = play_ptr + PTR_W'(1);
          data_n     = rd_data;
        end
      end

      WAIT_BUSY: begin
        if (pwm_busy) begin
          state_n = WAIT_DONE;
        end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
          state_n = GAP;
          timer_n = '0;
          // An all-zero line leaves every PWM output low, so no busy is
          // expected and the timeout is not an error.
          if (!play_zero) begin
            err_n = 1'b1;
          end
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!pwm_busy) begin
          state_n = GAP;
          timer_n = '0;
        end
      end

      GAP: begin
        if (timer == TMR_W'(GAP_CYCLES - 1)) begin
          state_n      = IDLE;
          release_bank = 1'b1;
          play_sel_n   = ~play_sel;
          done_n       = 1'b1;
          cnt_n        = line_cnt + LINE_CNT_W'(1);
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

endmodule
